// File: rtl/ps2_frame_receiver_pkg.sv
// Shared types and frame constants for the PS/2 frame receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_rx_state_t;

    localparam int unsigned SCAN_W     = 8;
    localparam int unsigned FRAME_BITS = 11;

endpackage

// File: rtl/ps2_frame_receiver.sv
// Deserialises one PS/2 frame (start, 8 data LSB-first, odd parity, stop) sampled on edge_found,
// reporting good bytes, parity errors and framing/timeout errors as one-cycle registered pulses.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              edge_found,
    input  logic              kb_data_sync,
    output logic [SCAN_W-1:0] scan_code,
    output logic              scan_code_valid,
    output logic              parity_err,
    output logic              frame_err
);

    localparam int unsigned TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned DATA_BITS = FRAME_BITS - 3;

    ps2_rx_state_t        state, state_nx;
    logic [SCAN_W-1:0]    shreg, shreg_nx;
    logic [2:0]           bit_cnt, bit_cnt_nx;
    logic                 par_bit, par_nx;
    logic [TIMEOUT_W-1:0] timer, timer_nx;
    logic [SCAN_W-1:0]    scan_code_nx;
    logic                 valid_nx, perr_nx, ferr_nx;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            shreg           <= '0;
            bit_cnt         <= '0;
            par_bit         <= 1'b0;
            timer           <= '0;
            scan_code       <= '0;
            scan_code_valid <= 1'b0;
            parity_err      <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            state           <= state_nx;
            shreg           <= shreg_nx;
            bit_cnt         <= bit_cnt_nx;
            par_bit         <= par_nx;
            timer           <= timer_nx;
            scan_code       <= scan_code_nx;
            scan_code_valid <= valid_nx;
            parity_err      <= perr_nx;
            frame_err       <= ferr_nx;
        end
    end

    // Next-state, datapath and pulse decode
    always_comb begin
        state_nx     = state;
        shreg_nx     = shreg;
        bit_cnt_nx   = bit_cnt;
        par_nx       = par_bit;
        timer_nx     = timer;
        scan_code_nx = scan_code;
        valid_nx     = 1'b0;
        perr_nx      = 1'b0;
        ferr_nx      = 1'b0;

        if (edge_found) begin
            timer_nx = '0;
        end else if (state != IDLE) begin
            timer_nx = timer + TIMEOUT_W'(1);
        end

        case (state)
            IDLE: begin
                timer_nx = '0;
                if (edge_found && !kb_data_sync) begin
                    state_nx   = DATA;
                    bit_cnt_nx = '0;
                end
            end
            DATA: begin
                if (edge_found) begin
                    shreg_nx   = {kb_data_sync, shreg[SCAN_W-1:1]};
                    bit_cnt_nx = bit_cnt + 3'(1);
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        state_nx = PARITY;
                    end
                end
            end
            PARITY: begin
                if (edge_found) begin
                    par_nx   = kb_data_sync;
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (edge_found) begin
                    state_nx = IDLE;
                    if (!kb_data_sync) begin
                        ferr_nx = 1'b1;
                    end else if (^{shreg, par_bit}) begin
                        scan_code_nx = shreg;
                        valid_nx     = 1'b1;
                    end else begin
                        perr_nx = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // A coincident edge takes priority over expiry
        if (state != IDLE && !edge_found && timer == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
            state_nx = IDLE;
            timer_nx = '0;
            ferr_nx  = 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: expected pulses are queued as frames are driven
// and checked (kind, scan_code, cycle) by a monitor when the DUT emits them.
module tb_ps2_frame_receiver;

    localparam int unsigned T_CYC   = 300;
    localparam int unsigned SPACING = 50;

    typedef struct {
        logic [1:0] kind;   // 0 valid, 1 parity_err, 2 frame_err
        logic [7:0] code;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       edge_found;
    logic       kb_data_sync;
    logic [7:0] scan_code;
    logic       scan_code_valid;
    logic       parity_err;
    logic       frame_err;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb[$];
    logic [7:0] model_sc;

    ps2_frame_receiver #(.TIMEOUT_CYCLES(T_CYC)) dut (
        .clk             (clk),
        .rst             (rst),
        .edge_found      (edge_found),
        .kb_data_sync    (kb_data_sync),
        .scan_code       (scan_code),
        .scan_code_valid (scan_code_valid),
        .parity_err      (parity_err),
        .frame_err       (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard
    exp_t       mon_e;
    logic [1:0] mon_k;
    always @(negedge clk) begin
        if (!rst && (scan_code_valid || parity_err || frame_err)) begin
            chk("pulse_onehot", 32'($onehot({scan_code_valid, parity_err, frame_err})), 32'd1);
            mon_k = scan_code_valid ? 2'd0 : (parity_err ? 2'd1 : 2'd2);
            chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("pulse_kind", 32'(mon_k), 32'(mon_e.kind));
                chk("pulse_code", 32'(scan_code), 32'(mon_e.code));
                chk("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    // One bit slot: data settles 10 clk before the strobe; optionally queue the expected pulse
    task automatic pulse(input logic b, input logic push_en, input exp_t item, output int ec);
        exp_t e;
        repeat (SPACING - 10) @(negedge clk);
        kb_data_sync = b;
        repeat (10) @(negedge clk);
        if (push_en) begin
            e     = item;
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
        edge_found = 1'b1;
        @(negedge clk);
        edge_found = 1'b0;
        ec = cyc;
    endtask

    task automatic frame(input logic [7:0] d, input logic par, input logic stop, input string tag);
        exp_t e;
        int   ec;
        e.cyc  = 0;
        e.kind = !stop ? 2'd2 : ((^{d, par}) ? 2'd0 : 2'd1);
        if (e.kind == 2'd0) model_sc = d;
        e.code = model_sc;
        pulse(1'b0, 1'b0, e, ec);
        for (int i = 0; i < 8; i++) pulse(d[i], 1'b0, e, ec);
        pulse(par, 1'b0, e, ec);
        pulse(stop, 1'b1, e, ec);
        repeat (5) @(negedge clk);
        chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
        chk({tag, "_scan_code"}, 32'(scan_code), 32'(model_sc));
    endtask

    initial begin
        exp_t       e;
        int         ec;
        logic [7:0] part;

        rst          = 1'b1;
        edge_found   = 1'b0;
        kb_data_sync = 1'b1;
        model_sc     = 8'h00;
        e.kind = 2'd0; e.code = 8'h00; e.cyc = 0;
        repeat (5) @(negedge clk);
        chk("rst_scan_code", 32'(scan_code), 32'h00);
        chk("rst_valid", 32'(scan_code_valid), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        frame(8'h1C, 1'b0, 1'b1, "good_1c");
        frame(8'h1C, 1'b1, 1'b1, "parity_1c");
        frame(8'h5A, 1'b1, 1'b0, "stop0_5a");

        // Spurious idle edge with data high must be ignored
        pulse(1'b1, 1'b0, e, ec);
        frame(8'hF0, 1'b1, 1'b1, "good_f0");

        // Start + 4 data bits then silence: frame_err exactly T_CYC after the last edge
        part = 8'h5A;
        pulse(1'b0, 1'b0, e, ec);
        for (int i = 0; i < 4; i++) pulse(part[i], 1'b0, e, ec);
        e.kind = 2'd2; e.code = model_sc; e.cyc = ec + int'(T_CYC);
        sb.push_back(e);
        repeat (T_CYC + 20) @(negedge clk);
        chk("timeout_drained", 32'(sb.size()), 32'd0);
        frame(8'h1C, 1'b0, 1'b1, "post_timeout_1c");

        // Reset mid-frame: outputs clear at once, partial frame discarded
        pulse(1'b0, 1'b0, e, ec);
        for (int i = 0; i < 5; i++) pulse(part[i], 1'b0, e, ec);
        rst = 1'b1;
        #1;
        chk("midrst_scan_code", 32'(scan_code), 32'h00);
        chk("midrst_pulses", 32'({scan_code_valid, parity_err, frame_err}), 32'd0);
        model_sc = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (SPACING * 3) @(negedge clk);
        chk("post_rst_scan_code", 32'(scan_code), 32'h00);
        chk("post_rst_drained", 32'(sb.size()), 32'd0);
        frame(8'h5A, 1'b1, 1'b1, "post_rst_5a");

        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
